// File: rtl/watch_set_ctrl_if.sv
// watch_set_ctrl_if: buttons, timekeeper time and load strobe shared by the watch UI and the set controller.
interface watch_set_ctrl_if;
   logic        clk1sec;
   logic        btn_mode, btn_up, btn_down;
   logic [7:0]  year, month, day, hour, minute, second;
   logic        set_time;
   logic [47:0] bin_time;
   logic        edit_active;
   logic [2:0]  edit_field;
   logic        blink;
   modport master (
      output clk1sec, btn_mode, btn_up, btn_down, year, month, day, hour, minute, second,
      input  set_time, bin_time, edit_active, edit_field, blink
   );
   modport slave (
      input  clk1sec, btn_mode, btn_up, btn_down, year, month, day, hour, minute, second,
      output set_time, bin_time, edit_active, edit_field, blink
   );
endinterface

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: button-driven time-setting FSM editing a shadow copy of the current time.
// Defining WATCH_SET_TIMEOUT_EN abandons an edit after 30 quiet seconds.
module watch_set_ctrl (
   input  logic clk,
   input  logic rst,
   watch_set_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, YEAR, MONTH, DAY, HOUR, MINUTE, SECOND, COMMIT} state_t;
   state_t state, next;
   logic [7:0] y, mo, d, h, mi, s;
   logic [7:0] md, cap_mo;
   logic blink_q, edit, adjust, cancel, timeout;

   function automatic logic [7:0] max_date(input logic [7:0] m, input logic [7:0] yr);
      logic leap;
      leap = (yr[1:0] == 2'd0) && (yr != 8'd100) && (yr != 8'd200);
      return (m == 8'd2) ? (leap ? 8'd29 : 8'd28) :
             (m == 8'd4 || m == 8'd6 || m == 8'd9 || m == 8'd11) ? 8'd30 : 8'd31;
   endfunction

   function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi, input logic up);
      return up ? ((v >= hi) ? lo : v + 8'd1) : ((v <= lo) ? hi : v - 8'd1);
   endfunction

   assign edit   = state != IDLE && state != COMMIT;
   assign adjust = edit && !bus.btn_mode && (bus.btn_up ^ bus.btn_down);
   assign cancel = edit && !bus.btn_mode && bus.btn_up && bus.btn_down;
   assign md     = max_date(mo, y);
   assign cap_mo = (bus.month == 8'd0 || bus.month > 8'd12) ? 8'd1 : bus.month;

`ifdef WATCH_SET_TIMEOUT_EN
   logic [4:0] quiet_secs;
   logic any_btn;
   assign any_btn = bus.btn_mode || bus.btn_up || bus.btn_down;
   always_ff @(posedge clk)
      if (rst || !edit || any_btn) quiet_secs <= '0;
      else if (bus.clk1sec) quiet_secs <= quiet_secs + 5'd1;
   assign timeout = edit && !any_btn && bus.clk1sec && quiet_secs == 5'd29;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk)
      if (rst) begin
         state   <= IDLE;
         blink_q <= 1'b0;
      end else begin
         state   <= next;
         blink_q <= (state == IDLE) ? 1'b0 : blink_q ^ bus.clk1sec;
      end

   always_comb
      next = (state == IDLE)   ? (bus.btn_mode ? YEAR : IDLE) :
             (state == COMMIT) ? IDLE :
             bus.btn_mode      ? state_t'(state + 3'd1) :
             (cancel || timeout) ? IDLE : state;

   // Shadow: captured on edit entry, day clamped when leaving MONTH, stepped by up/down.
   always_ff @(posedge clk)
      if (rst) begin
         {y, mo, d, h, mi, s} <= {8'd21, 8'd5, 8'd30, 8'd0, 8'd0, 8'd0};
      end else if (state == IDLE && bus.btn_mode) begin
         y  <= bus.year;
         mo <= cap_mo;
         d  <= (bus.day == 8'd0 || bus.day > max_date(cap_mo, bus.year)) ? 8'd1 : bus.day;
         h  <= bus.hour;
         mi <= bus.minute;
         s  <= bus.second;
      end else if (state == MONTH && bus.btn_mode) begin
         d  <= (d > md) ? md : d;
      end else if (adjust) begin
         case (state)
            YEAR:    y  <= step(y,  8'd0, 8'd255, bus.btn_up);
            MONTH:   mo <= step(mo, 8'd1, 8'd12,  bus.btn_up);
            DAY:     d  <= step(d,  8'd1, md,     bus.btn_up);
            HOUR:    h  <= step(h,  8'd0, 8'd23,  bus.btn_up);
            MINUTE:  mi <= step(mi, 8'd0, 8'd59,  bus.btn_up);
            SECOND:  s  <= step(s,  8'd0, 8'd59,  bus.btn_up);
            default: ;
         endcase
      end

   always_comb begin
      bus.set_time    = state == COMMIT;
      bus.edit_active = state != IDLE;
      bus.edit_field  = state;
      bus.blink       = blink_q && state != IDLE;
      bus.bin_time    = {y, mo, d, h, mi, s};
   end
endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed and random button sequences checked against a field-array model of the setter.
module tb_watch_set_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   watch_set_ctrl_if bus ();
   watch_set_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0, errors = 0;
   int f[6];
   int lo[6] = '{0, 1, 1, 0, 0, 0};
   int hi[6] = '{255, 12, 31, 23, 59, 59};
   int pos, quiet;
   bit mblink;

   function automatic int mdays(int m, int yr);
      bit leap;
      leap = (yr % 4 == 0) && yr != 100 && yr != 200;
      if (m == 2) return leap ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic logic [47:0] shadow();
      return {8'(f[0]), 8'(f[1]), 8'(f[2]), 8'(f[3]), 8'(f[4]), 8'(f[5])};
   endfunction

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      f = '{21, 5, 30, 0, 0, 0};
      pos = 0;
      quiet = 0;
      mblink = 1'b0;
   endtask

   task automatic set_inputs(input int yr, input int mo, input int dy, input int hr, input int mn, input int sc);
      bus.year = 8'(yr); bus.month = 8'(mo); bus.day = 8'(dy);
      bus.hour = 8'(hr); bus.minute = 8'(mn); bus.second = 8'(sc);
   endtask

   // One clock with the given pulses; the model advances, then every output is compared.
   task automatic step(input bit m, input bit u, input bit dn, input bit t);
      int k, top, n, mm, dd;
      bus.btn_mode = m; bus.btn_up = u; bus.btn_down = dn; bus.clk1sec = t;
      mblink = (pos == 0) ? 1'b0 : mblink ^ t;
      if (rst) model_reset();
      else if (pos == 0) begin
         if (m) begin
            f[0] = int'(bus.year);
            mm = int'(bus.month);
            f[1] = (mm < 1 || mm > 12) ? 1 : mm;
            dd = int'(bus.day);
            f[2] = (dd < 1 || dd > mdays(f[1], f[0])) ? 1 : dd;
            f[3] = int'(bus.hour); f[4] = int'(bus.minute); f[5] = int'(bus.second);
            pos = 1;
         end
      end else if (pos == 7) pos = 0;
      else if (m) begin
         if (pos == 2 && f[2] > mdays(f[1], f[0])) f[2] = mdays(f[1], f[0]);
         pos++;
         quiet = 0;
      end else if (u && dn) pos = 0;
      else if (u || dn) begin
         k = pos - 1;
         top = (k == 2) ? mdays(f[1], f[0]) : hi[k];
         n = top - lo[k] + 1;
         f[k] = lo[k] + (f[k] - lo[k] + (u ? 1 : n - 1)) % n;
         quiet = 0;
      end else if (t) begin
         quiet++;
`ifdef WATCH_SET_TIMEOUT_EN
         if (quiet == 30) pos = 0;
`endif
      end
      if (pos == 0 || pos == 7) quiet = 0;
      @(posedge clk);
      #1;
      bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.clk1sec = 1'b0;
      check("edit_field", 48'(bus.edit_field), 48'(pos));
      check("edit_active", 48'(bus.edit_active), 48'(pos != 0));
      check("set_time", 48'(bus.set_time), 48'(pos == 7));
      check("blink", 48'(bus.blink), 48'(mblink && pos != 0));
      check("bin_time", bus.bin_time, shadow());
   endtask

   int exp_day[3] = '{29, 28, 28};
   int yrs[3] = '{24, 25, 100};
   bit expect_active;

   initial begin
      bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.clk1sec = 1'b0;
      set_inputs(0, 0, 0, 0, 0, 0);
      model_reset();
      rst = 1'b1;
      step(0, 0, 0, 0);
      step(1, 0, 0, 1);
      rst = 1'b0;
      check("reset_bin_time", bus.bin_time, 48'h15051E000000);
      check("reset_field", 48'(bus.edit_field), 48'd0);

      set_inputs(21, 5, 30, 10, 20, 30);
      step(1, 0, 0, 0);
      check("capture", bus.bin_time, {8'd21, 8'd5, 8'd30, 8'd10, 8'd20, 8'd30});
      check("capture_field", 48'(bus.edit_field), 48'd1);
      step(0, 1, 1, 0);

      set_inputs(255, 1, 15, 23, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      check("year_wrap", 48'(bus.bin_time[47:40]), 48'd0);
      step(1, 0, 0, 1);
      step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      check("month_wrap", 48'(bus.bin_time[39:32]), 48'd11);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 1);
      check("hour_wrap", 48'(bus.bin_time[23:16]), 48'd0);
      step(1, 1, 0, 0);
      check("mode_priority_field", 48'(bus.edit_field), 48'd5);
      check("mode_priority_hour", 48'(bus.bin_time[23:16]), 48'd0);
      step(0, 1, 1, 0);
      check("cancel_field", 48'(bus.edit_field), 48'd0);
      check("cancel_shadow", bus.bin_time, {8'd0, 8'd11, 8'd15, 8'd0, 8'd0, 8'd0});

      for (int i = 0; i < 3; i++) begin
         set_inputs(yrs[i] - 1, 1, 31, 7, 8, 9);
         step(1, 0, 0, 0);
         step(0, 1, 0, 0);
         step(1, 0, 0, 0);
         step(0, 1, 0, 0);
         step(1, 0, 0, 0);
         check("day_clamp", 48'(bus.bin_time[31:24]), 48'(exp_day[i]));
         for (int j = 0; j < 4; j++) step(1, 0, 0, 0);
         check("commit_strobe", 48'(bus.set_time), 48'd1);
         step(0, 0, 0, 0);
         check("commit_done", 48'(bus.set_time), 48'd0);
      end

      set_inputs(30, 6, 15, 12, 30, 45);
      step(1, 0, 0, 0);
      for (int j = 0; j < 5; j++) step(1, 0, 0, 0);
      rst = 1'b1;
      step(1, 0, 0, 0);
      rst = 1'b0;
      check("abort_edit", 48'(bus.set_time), 48'd0);
      step(1, 0, 0, 0);
      for (int j = 0; j < 6; j++) step(1, 0, 0, 0);
      rst = 1'b1;
      step(0, 0, 0, 0);
      rst = 1'b0;
      check("abort_commit", 48'(bus.set_time), 48'd0);

      set_inputs(10, 3, 3, 3, 3, 3);
      step(1, 0, 0, 0);
      for (int j = 0; j < 29; j++) begin
         step(0, 0, 0, 1);
         step(0, 0, 0, 0);
      end
      step(0, 1, 0, 0);
      check("timeout_cleared", 48'(bus.edit_active), 48'd1);
      for (int j = 0; j < 30; j++) step(0, 0, 0, 1);
`ifdef WATCH_SET_TIMEOUT_EN
      expect_active = 1'b0;
`else
      expect_active = 1'b1;
`endif
      check("timeout", 48'(bus.edit_active), 48'(expect_active));
      step(0, 1, 1, 0);

      for (int i = 0; i < 600; i++) begin
         int r;
         if (pos == 0)
            set_inputs($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 31),
                       $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
         r = $urandom_range(0, 19);
         step(r < 4, r >= 4 && r < 10, r >= 10 && r < 16, $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
